// File: rtl/lcd_bus_scheduler.sv
// HD44780 8-bit character LCD sequencer: runs the power-up init table, then shares the bus between
// requesters A and B with round-robin arbitration. Optional macro LCD_AUTO_NEWLINE_EN adds cursor tracking.
module lcd_bus_scheduler #(
   parameter int T_PWRUP_CYC = 1000000,
   parameter int T_SETUP_CYC = 4,
   parameter int T_EN_CYC    = 25,
   parameter int T_CMD_CYC   = 2500,
   parameter int T_CLR_CYC   = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a_valid,
   input  logic       a_rs,
   input  logic [7:0] a_data,
   output logic       a_ready,
   input  logic       b_valid,
   input  logic       b_rs,
   input  logic [7:0] b_data,
   output logic       b_ready,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_en,
   output logic       init_done,
   output logic       busy
);

   localparam int M1      = (T_PWRUP_CYC > T_CLR_CYC) ? T_PWRUP_CYC : T_CLR_CYC;
   localparam int M2      = (M1 > T_CMD_CYC) ? M1 : T_CMD_CYC;
   localparam int M3      = (M2 > T_EN_CYC) ? M2 : T_EN_CYC;
   localparam int CNT_MAX = (M3 > T_SETUP_CYC) ? M3 : T_SETUP_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] LD_PWRUP = CW'(T_PWRUP_CYC - 1);
   localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP_CYC - 1);
   localparam logic [CW-1:0] LD_EN    = CW'(T_EN_CYC - 1);
   localparam logic [CW-1:0] LD_CMD   = CW'(T_CMD_CYC - 1);
   localparam logic [CW-1:0] LD_CLR   = CW'(T_CLR_CYC - 1);

   typedef enum logic [2:0] {PWRUP, SETUP, EN_HI, DELAY, IDLE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    init_idx;
   logic          prefer_b;

   logic          can_accept;
   logic          grant_a;
   logic          grant_b;
   logic          take;
   logic          take_rs;
   logic [7:0]    take_data;
   logic          long_delay;
   logic          insert_nl;
   logic [7:0]    nl_cmd;

   function automatic logic [7:0] init_byte(input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0, 3'd1, 3'd2: b = 8'h38;
         3'd3:             b = 8'h0C;
         3'd4:             b = 8'h01;
         default:          b = 8'h06;
      endcase
      return b;
   endfunction

   // Handshake: a byte moves when valid & ready are both high at a rising clk edge. ready is a
   // combinational grant, only ever high in IDLE after init; a requester holds valid/rs/data until taken.
   assign can_accept = (state == IDLE) && init_done;
   assign grant_a    = can_accept && a_valid && (!b_valid || !prefer_b);
   assign grant_b    = can_accept && b_valid && (!a_valid || prefer_b);
   assign a_ready    = grant_a;
   assign b_ready    = grant_b;
   assign take       = grant_a || grant_b;
   assign take_rs    = grant_a ? a_rs : b_rs;
   assign take_data  = grant_a ? a_data : b_data;
   assign busy       = (state != IDLE);

   // The first three init words need the long wait regardless of their value.
   assign long_delay = (!init_done && (init_idx < 3'd3)) ||
                       (!lcd_rs && ((lcd_data == 8'h01) || (lcd_data == 8'h02) || (lcd_data == 8'h03)));

`ifdef LCD_AUTO_NEWLINE_EN
   logic       line;
   logic [3:0] col;
   logic       nl_pend;

   assign insert_nl = (state == DELAY) && (cnt == '0) && init_done && nl_pend;
   assign nl_cmd    = line ? 8'h80 : 8'hC0;

   always_ff @(posedge clk) begin
      if (rst) begin
         line    <= 1'b0;
         col     <= 4'd0;
         nl_pend <= 1'b0;
      end else if ((state == DELAY) && (cnt == '0) && !init_done && (init_idx == 3'd3)) begin
         line <= 1'b0;
         col  <= 4'd0;
      end else if (insert_nl) begin
         line    <= ~line;
         nl_pend <= 1'b0;
      end else if (take) begin
         if (take_rs) begin
            col <= col + 4'd1;
            if (col == 4'hF) nl_pend <= 1'b1;
         end else if (take_data[7]) begin
            line <= take_data[6];
            col  <= take_data[3:0];
         end else if ((take_data == 8'h01) || (take_data == 8'h02) || (take_data == 8'h03)) begin
            line <= 1'b0;
            col  <= 4'd0;
         end
      end
   end
`else
   assign insert_nl = 1'b0;
   assign nl_cmd    = 8'hC0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= PWRUP;
         cnt       <= LD_PWRUP;
         init_idx  <= 3'd0;
         init_done <= 1'b0;
         prefer_b  <= 1'b0;
         lcd_data  <= 8'h00;
         lcd_rs    <= 1'b0;
         lcd_en    <= 1'b0;
      end else begin
         case (state)
            PWRUP: begin
               if (cnt == '0) begin
                  init_idx <= 3'd0;
                  lcd_data <= init_byte(3'd0);
                  lcd_rs   <= 1'b0;
                  state    <= SETUP;
                  cnt      <= LD_SETUP;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  lcd_en <= 1'b1;
                  state  <= EN_HI;
                  cnt    <= LD_EN;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            EN_HI: begin
               if (cnt == '0) begin
                  lcd_en <= 1'b0;
                  state  <= DELAY;
                  cnt    <= long_delay ? LD_CLR : LD_CMD;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DELAY: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else if (!init_done) begin
                  if (init_idx == 3'd5) begin
                     init_done <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     init_idx <= init_idx + 3'd1;
                     lcd_data <= init_byte(init_idx + 3'd1);
                     state    <= SETUP;
                     cnt      <= LD_SETUP;
                  end
               end else if (insert_nl) begin
                  lcd_data <= nl_cmd;
                  lcd_rs   <= 1'b0;
                  state    <= SETUP;
                  cnt      <= LD_SETUP;
               end else begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (take) begin
                  lcd_data <= take_data;
                  lcd_rs   <= take_rs;
                  prefer_b <= grant_a;
                  state    <= SETUP;
                  cnt      <= LD_SETUP;
               end
            end
            default: begin
               state <= PWRUP;
               cnt   <= LD_PWRUP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Scoreboard bench for lcd_bus_scheduler: expected {rs,data} per EN pulse is queued by the stimulus,
// a negedge monitor pops and compares; directed timing checks use hand-computed cycle offsets.
module tb_lcd_bus_scheduler;

   localparam int T_PWRUP = 20;
   localparam int T_SETUP = 2;
   localparam int T_EN    = 3;
   localparam int T_CMD   = 5;
   localparam int T_CLR   = 10;
`ifdef LCD_AUTO_NEWLINE_EN
   localparam int NL = 1;
`else
   localparam int NL = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a_valid = 1'b0, a_rs = 1'b0, a_ready;
   logic [7:0] a_data = 8'h00;
   logic       b_valid = 1'b0, b_rs = 1'b0, b_ready;
   logic [7:0] b_data = 8'h00;
   logic [7:0] lcd_data;
   logic       lcd_rs, lcd_en, init_done, busy;

   lcd_bus_scheduler #(
      .T_PWRUP_CYC(T_PWRUP), .T_SETUP_CYC(T_SETUP), .T_EN_CYC(T_EN),
      .T_CMD_CYC(T_CMD), .T_CLR_CYC(T_CLR)
   ) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_rs(a_rs), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_rs(b_rs), .b_data(b_data), .b_ready(b_ready),
      .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_en(lcd_en),
      .init_done(init_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [8:0] exp_q[$];
   int         rise_log[$];
   int         init_off[6] = '{22, 37, 52, 67, 77, 92};
   int         b_acc0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: one scoreboard pop per EN rising edge, plus pulse-width and bus-stability checks.
   logic       en_q = 1'b0;
   logic [8:0] cur_word;
   int         rise_at;
   bit         rst_in_pulse;
   initial begin
      forever begin
         @(negedge clk);
         if (lcd_en && !en_q) begin
            rise_at      = cyc;
            cur_word     = {lcd_rs, lcd_data};
            rst_in_pulse = 1'b0;
            rise_log.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL pulse_unexpected: got %0h, expected no pulse (cycle %0d)", cur_word, cyc);
            end else begin
               check("pulse_word", {23'd0, lcd_rs, lcd_data}, {23'd0, exp_q.pop_front()});
            end
         end
         if (lcd_en && en_q) check("bus_stable_during_en", {23'd0, lcd_rs, lcd_data}, {23'd0, cur_word});
         if (lcd_en && rst) rst_in_pulse = 1'b1;
         if (!lcd_en && en_q && !rst_in_pulse && !rst) check("en_width", cyc - rise_at, T_EN);
         if (a_ready || b_ready) begin
            check("single_ready", {31'd0, a_ready && b_ready}, 0);
            check("ready_only_idle_after_init", {31'd0, busy || !init_done}, 0);
         end
         en_q = lcd_en;
      end
   end

   task automatic send_a(input logic rs_i, input logic [7:0] d, output int acc);
      bit done = 0;
      acc = -1;
      a_valid = 1'b1; a_rs = rs_i; a_data = d;
      for (int i = 0; i < 400 && !done; i++) begin
         #1;
         if (a_ready) begin acc = cyc; done = 1; end
         @(negedge clk);
      end
      a_valid = 1'b0;
      if (!done) check("a_accept_timeout", 0, 1);
   endtask

   task automatic send_b(input logic rs_i, input logic [7:0] d, output int acc);
      bit done = 0;
      acc = -1;
      b_valid = 1'b1; b_rs = rs_i; b_data = d;
      for (int i = 0; i < 400 && !done; i++) begin
         #1;
         if (b_ready) begin acc = cyc; done = 1; end
         @(negedge clk);
      end
      b_valid = 1'b0;
      if (!done) check("b_accept_timeout", 0, 1);
   endtask

   task automatic push_init();
      exp_q.push_back({1'b0, 8'h38});
      exp_q.push_back({1'b0, 8'h38});
      exp_q.push_back({1'b0, 8'h38});
      exp_q.push_back({1'b0, 8'h0C});
      exp_q.push_back({1'b0, 8'h01});
      exp_q.push_back({1'b0, 8'h06});
   endtask

   task automatic check_init(input int r0);
      int done_at = -1;
      for (int i = 0; i < 300 && done_at < 0; i++) begin
         if (init_done) done_at = cyc;
         else @(negedge clk);
      end
      check("init_done_cycle", done_at - r0, 100);
      check("init_pulse_count", rise_log.size(), 6);
      for (int k = 0; k < 6; k++)
         if (k < rise_log.size()) check($sformatf("init_rise_%0d", k), rise_log[k] - r0, init_off[k]);
   endtask

   task automatic wait_drain();
      int i = 0;
      while ((exp_q.size() != 0 || busy) && i < 500) begin
         @(negedge clk);
         i++;
      end
      check("drain_queue_empty", exp_q.size(), 0);
      check("drain_idle", {31'd0, busy}, 0);
   endtask

   initial begin
      int r0, n, n2, sz, found;
      int acc6[32];

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_lcd_data", lcd_data, 8'h00);
      check("rst_lcd_rs", lcd_rs, 0);
      check("rst_lcd_en", lcd_en, 0);
      check("rst_init_done", init_done, 0);
      check("rst_busy", busy, 1);
      check("rst_readies", {a_ready, b_ready}, 0);

      // Init sequence, with a B byte left pending throughout
      rst = 1'b0;
      r0 = cyc;
      push_init();
      exp_q.push_back({1'b1, 8'h42});
      fork
         send_b(1'b1, 8'h42, b_acc0);
      join_none
      check_init(r0);
      wait_drain();
      check("pending_b_accept_cycle", b_acc0 - r0, 100);

      // Single A data byte: bus latch, EN window, earliest next accept
      exp_q.push_back({1'b1, 8'h41});
      sz = rise_log.size();
      send_a(1'b1, 8'h41, n);
      check("t2_latch_data", lcd_data, 8'h41);
      check("t2_latch_rs", lcd_rs, 1);
      check("t2_en_low_in_setup", lcd_en, 0);
      exp_q.push_back({1'b1, 8'h44});
      send_a(1'b1, 8'h44, n2);
      check("t2_next_accept_gap", n2 - n, 11);
      if (rise_log.size() > sz) check("t2_en_rise_offset", rise_log[sz] - n, 3);
      else check("t2_en_rise_missing", 0, 1);
      wait_drain();

      // Clear command from B uses the long delay
      exp_q.push_back({1'b0, 8'h01});
      exp_q.push_back({1'b1, 8'h43});
      send_b(1'b0, 8'h01, n);
      send_b(1'b1, 8'h43, n2);
      check("t4_clear_accept_gap", n2 - n, 16);
      wait_drain();

      // Reset during EN_HI aborts the pulse and replays init
      exp_q.push_back({1'b1, 8'h55});
      send_a(1'b1, 8'h55, n);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         if (lcd_en) found = 1;
         else @(negedge clk);
      end
      check("t5_en_seen", found, 1);
      rst = 1'b1;
      @(negedge clk);
      check("t5_en_dropped", lcd_en, 0);
      check("t5_init_done_cleared", init_done, 0);
      check("t5_busy", busy, 1);
      check("t5_lcd_data", lcd_data, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      r0 = cyc;
      rise_log.delete();
      push_init();
      check_init(r0);

      // Both requesters hold valid: grants alternate starting with A
      sz = rise_log.size();
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back({1'b1, 8'(8'hA0 + k)});
         exp_q.push_back({1'b1, 8'(8'hB0 + k)});
      end
      fork
         begin
            int t;
            for (int k = 0; k < 3; k++) send_a(1'b1, 8'(8'hA0 + k), t);
         end
         begin
            int t;
            for (int k = 0; k < 3; k++) send_b(1'b1, 8'(8'hB0 + k), t);
         end
      join
      wait_drain();
      check("t3_pulse_count", rise_log.size() - sz, 6);

      // 32 data bytes from column 0: newline commands only with the auto-newline build
      sz = rise_log.size();
      exp_q.push_back({1'b0, 8'h80});
      send_a(1'b0, 8'h80, n);
      for (int k = 0; k < 32; k++) begin
         exp_q.push_back({1'b1, 8'(8'h40 + k)});
         send_a(1'b1, 8'(8'h40 + k), acc6[k]);
         if (NL == 1 && k == 15) exp_q.push_back({1'b0, 8'hC0});
         if (NL == 1 && k == 31) exp_q.push_back({1'b0, 8'h80});
      end
      wait_drain();
      check("t6_gap_normal", acc6[1] - acc6[0], 11);
      check("t6_gap_after_wrap", acc6[16] - acc6[15], 11 + 10 * NL);
      check("t6_gap_after_newline", acc6[17] - acc6[16], 11);
      check("t6_pulse_count", rise_log.size() - sz, 33 + 2 * NL);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, expected finish before cycle 40000");
      $fatal(1, "watchdog expired");
   end

endmodule
